// File: rtl/ha_array_reduce_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ha_array_pkg
//  Brief    : Shared widths, row struct and weight helper for the HA reducer.
//  Revision : 1.0  initial release
// ============================================================================
package ha_array_pkg;

    localparam int HA_T_W    = 9;
    localparam int HA_B_W    = 7;
    localparam int HA_ARRAYS = 4;
    localparam int SUM_W     = 17;
    localparam int ROW_W     = 16;
    localparam int PART_W    = 13;

    typedef struct packed {
        logic [HA_T_W-1:0] t;
        logic [HA_B_W-1:0] b;
    } ha_row_t;

    function automatic int row_weight_shift(input int k);
        return 2 * k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ha_array_reduce_pipe_row_align.sv
`default_nettype none
// ============================================================================
//  Module   : ha_row_align
//  Brief    : Combines one HA array's t/b rows and shifts to the array weight.
//  Revision : 1.0  initial release
// ============================================================================
module ha_row_align
    import ha_array_pkg::*;
#(
    parameter int K = 0
) (
    input  ha_row_t          row_in,
    output logic [ROW_W-1:0] row_out
);

    logic [ROW_W-1:0] w_row_local;

    // b sits two bit positions above t inside each array
    assign w_row_local = ROW_W'(row_in.t) + ROW_W'({row_in.b, 2'b00});
    assign row_out     = w_row_local << row_weight_shift(K);

endmodule
`default_nettype wire

// File: rtl/ha_array_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ha_array_reduce_pipe
//  Brief    : Two-stage valid/ready reducer summing four HA array row pairs
//             into the 16-bit approximate product with overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module ha_array_reduce_pipe
    import ha_array_pkg::*;
#(
    parameter bit SAT_EN = 1'b1,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HA_T_W-1:0] ha_array_0_t,
    input  logic [HA_B_W-1:0] ha_array_0_b,
    input  logic [HA_T_W-1:0] ha_array_1_t,
    input  logic [HA_B_W-1:0] ha_array_1_b,
    input  logic [HA_T_W-1:0] ha_array_2_t,
    input  logic [HA_B_W-1:0] ha_array_2_b,
    input  logic [HA_T_W-1:0] ha_array_3_t,
    input  logic [HA_B_W-1:0] ha_array_3_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  product,
    output logic              ovf
);

    ha_row_t           w_rows    [HA_ARRAYS];
    logic [ROW_W-1:0]  w_aligned [HA_ARRAYS];
    logic [ROW_W-1:0]  w_pa_full;
    logic [ROW_W-1:0]  w_pb_full;
    logic [SUM_W-1:0]  w_sum;
    logic [OUT_W-1:0]  w_product;
    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_unused_bits;

    logic              r_s1_valid;
    logic [PART_W-1:0] r_pa;
    logic [PART_W-1:0] r_pb;
    logic              r_s2_valid;
    logic [OUT_W-1:0]  r_product;
    logic              r_ovf;

    assign w_rows[0] = {ha_array_0_t, ha_array_0_b};
    assign w_rows[1] = {ha_array_1_t, ha_array_1_b};
    assign w_rows[2] = {ha_array_2_t, ha_array_2_b};
    assign w_rows[3] = {ha_array_3_t, ha_array_3_b};

    for (genvar k = 0; k < HA_ARRAYS; k++) begin : g_row
        ha_row_align #(
            .K (k)
        ) u_align (
            .row_in  (w_rows[k]),
            .row_out (w_aligned[k])
        );
    end

    // pb is kept relative to weight 2^4; the low nibble of rows 2/3 is always zero
    assign w_pa_full = w_aligned[0] + w_aligned[1];
    assign w_pb_full = {4'b0000, w_aligned[2][ROW_W-1:4]}
                     + {4'b0000, w_aligned[3][ROW_W-1:4]};

    assign w_unused_bits = ^{w_pa_full[ROW_W-1:PART_W], w_pb_full[ROW_W-1:PART_W],
                             w_aligned[2][3:0], w_aligned[3][3:0]};

    assign w_sum = {4'b0000, r_pa} + {r_pb, 4'b0000};

    always_comb begin
        w_product = w_sum[OUT_W-1:0];
        if (SAT_EN && w_sum[SUM_W-1]) begin
            w_product = {OUT_W{1'b1}};
        end
    end

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_pa       <= '0;
            r_pb       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_pa <= w_pa_full[PART_W-1:0];
                r_pb <= w_pb_full[PART_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_product  <= '0;
            r_ovf      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_product;
                r_ovf     <= w_sum[SUM_W-1];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign product   = r_product;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ha_array_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ha_array_reduce_pipe
//  Brief    : Directed + random bench for the saturating and truncating builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ha_array_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [8:0]  tb_t [4];
    logic [6:0]  tb_b [4];

    logic        in_ready_s, in_ready_t;
    logic        out_valid_s, out_valid_t;
    logic        ovf_s, ovf_t;
    logic [15:0] product_s, product_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    int unsigned exp_q [$];

    logic        prev_stall   = 1'b0;
    logic [15:0] prev_product = '0;
    logic        prev_ovf     = 1'b0;

    always #5 clk = ~clk;

    ha_array_reduce_pipe #(.SAT_EN(1'b1), .OUT_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ha_array_0_t(tb_t[0]), .ha_array_0_b(tb_b[0]),
        .ha_array_1_t(tb_t[1]), .ha_array_1_b(tb_b[1]),
        .ha_array_2_t(tb_t[2]), .ha_array_2_b(tb_b[2]),
        .ha_array_3_t(tb_t[3]), .ha_array_3_b(tb_b[3]),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .product(product_s), .ovf(ovf_s)
    );

    ha_array_reduce_pipe #(.SAT_EN(1'b0), .OUT_W(16)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .ha_array_0_t(tb_t[0]), .ha_array_0_b(tb_b[0]),
        .ha_array_1_t(tb_t[1]), .ha_array_1_b(tb_b[1]),
        .ha_array_2_t(tb_t[2]), .ha_array_2_b(tb_b[2]),
        .ha_array_3_t(tb_t[3]), .ha_array_3_b(tb_b[3]),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .product(product_t), .ovf(ovf_t)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Product as the plain weighted sum of every input bit
    function automatic int unsigned ref_sum();
        int unsigned s = 0;
        for (int k = 0; k < 4; k++) begin
            s += 32'(tb_t[k]) * (32'd1 << (2 * k));
            s += 32'(tb_b[k]) * (32'd1 << (2 * k + 2));
        end
        return s;
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            tb_t[k] = '0;
            tb_b[k] = '0;
        end
    endtask

    task automatic send();
        bit done   = 1'b0;
        int waited = 0;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready_s) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 20) begin
                    check("send_timeout", 32'(in_ready_s), 1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: handshakes observed at the falling edge complete on the next rising edge
    initial begin
        int unsigned e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid_s), 1);
                    check("hold_product", 32'(product_s), 32'(prev_product));
                    check("hold_ovf", 32'(ovf_s), 32'(prev_ovf));
                end
                if (out_valid_s && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'(out_valid_s), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("product_sat", 32'(product_s), (e > 32'hFFFF) ? 32'hFFFF : e);
                        check("ovf_sat", 32'(ovf_s), 32'(e > 32'hFFFF));
                        check("trunc_valid", 32'(out_valid_t), 1);
                        check("product_trunc", 32'(product_t), e & 32'hFFFF);
                        check("ovf_trunc", 32'(ovf_t), 32'(e > 32'hFFFF));
                    end
                    n_out++;
                end
                if (in_valid && in_ready_s) begin
                    exp_q.push_back(ref_sum());
                end
                prev_stall   = out_valid_s && !out_ready;
                prev_product = product_s;
                prev_ovf     = ovf_s;
            end
        end
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_s), 0);
        check("rst_product", 32'(product_s), 0);
        check("rst_ovf", 32'(ovf_s), 0);
        check("rst_in_ready", 32'(in_ready_s), 1);
        @(posedge clk);
        #1;

        // Single beat: t0 = 1, two-cycle latency
        tb_t[0] = 9'h001;
        send();
        check("lat_not_yet", 32'(out_valid_s), 0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid_s), 1);
        check("p_one", 32'(product_s), 1);
        check("p_one_ovf", 32'(ovf_s), 0);

        clear_inputs();
        tb_b[3] = 7'h40;
        send();
        @(posedge clk);
        #1;
        check("p_b3_msb", 32'(product_s), 16384);
        check("p_b3_ovf", 32'(ovf_s), 0);

        for (int k = 0; k < 4; k++) begin
            tb_t[k] = 9'h1FF;
            tb_b[k] = 7'h7F;
        end
        send();
        @(posedge clk);
        #1;
        check("p_max_sat", 32'(product_s), 32'hFFFF);
        check("p_max_sat_ovf", 32'(ovf_s), 1);
        check("p_max_trunc", 32'(product_t), 21079);
        check("p_max_trunc_ovf", 32'(ovf_t), 1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two beats fill the pipe, third waits
        out_ready = 1'b0;
        base      = n_out;
        clear_inputs();
        tb_t[0] = 9'd5;
        send();
        tb_t[0] = 9'd9;
        send();
        tb_t[0]  = 9'd300;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready_s), 0);
            check("stall_valid", 32'(out_valid_s), 1);
            check("stall_product", 32'(product_s), 5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send();
        repeat (4) @(posedge clk);
        #1;
        check("stall_count", 32'(n_out - base), 3);

        // Full-rate random stream
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) begin
                tb_t[k] = 9'($urandom);
                tb_b[k] = 7'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    tb_t[k] = 9'h1FF;
                    tb_b[k] = 7'h7F;
                end
            end
            send();
        end
        check("tput_partial", 32'(n_out - base), 98);
        repeat (2) @(posedge clk);
        #1;
        check("tput_total", 32'(n_out - base), 100);
        check("tput_queue_empty", 32'(exp_q.size()), 0);

        // Reset with both stages full discards everything in flight
        out_ready = 1'b0;
        base      = n_out;
        clear_inputs();
        tb_t[0] = 9'd7;
        send();
        tb_t[0] = 9'd11;
        send();
        check("pre_rst_valid", 32'(out_valid_s), 1);
        check("pre_rst_in_ready", 32'(in_ready_s), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid_s), 0);
        check("mid_rst_product", 32'(product_s), 0);
        check("mid_rst_ovf", 32'(ovf_s), 0);
        check("mid_rst_trunc_product", 32'(product_t), 0);
        check("mid_rst_in_ready", 32'(in_ready_s), 1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_ghost", 32'(n_out - base), 0);
        check("mid_rst_queue", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ha_array_reduce_pipe.md
Name: ha_array_reduce_pipe

Overview:
- Downstream consumer of the 8x8 approximate half-adder-array stage.
- Takes the four ha_array t/b row pairs, aligns them to their bit weights and sums them to the unsigned product.
- Two-stage registered pipeline with valid/ready handshake on both sides.
- Sits between the partial-product/HA stage and the result bus of the approximate-multiplier datapath.

Parameters:
- SAT_EN, 1: 1 = clamp sums above 16'hFFFF to 16'hFFFF; 0 = truncate to the low 16 bits. ovf is raised in both cases.
- OUT_W, 16: product width; fixed at 16 for the 8x8 configuration.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  the ha_array_* inputs carry a valid operand set
- in_ready  out  1  block can accept this cycle
- ha_array_0_t  in  9  array 0 top row; bit i has weight 2^i
- ha_array_0_b  in  7  array 0 bottom row; bit i has weight 2^(i+2)
- ha_array_1_t / ha_array_1_b  in  9 / 7  array 1 rows; weights as array 0, shifted by 2
- ha_array_2_t / ha_array_2_b  in  9 / 7  array 2 rows; weights as array 0, shifted by 4
- ha_array_3_t / ha_array_3_b  in  9 / 7  array 3 rows; weights as array 0, shifted by 6
- out_valid  out  1  product is valid
- out_ready  in  1  downstream accepts the product
- product  out  OUT_W  approximate product
- ovf  out  1  the 17-bit internal sum exceeded 16'hFFFF; qualified by out_valid

Behaviour:
- Weights: array k contributes t_k<<(2k) plus b_k<<(2k+2). All arithmetic is unsigned.
- Internal sum width is 17 bits. Worst case is 1019*85 = 86615.
- Stage 1 (S1):
  - row_k = t_k + (b_k<<2), 10 bits, for k = 0..3.
  - pa = row_0 + (row_1<<2), 13 bits.
  - pb = row_2 + (row_3<<2), 13 bits.
  - Register pa, pb and s1_valid.
- Stage 2 (S2):
  - sum17 = pa + (pb<<4).
  - Register product, ovf and s2_valid.
  - product = SAT_EN ? (sum17[16] ? 16'hFFFF : sum17[15:0]) : sum17[15:0].
  - ovf = sum17[16].
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational ready chain with no skid buffer.
- Latency: an input accepted in cycle N has out_valid high from cycle N+2 when out_ready stays high.
- Throughput: 1 transfer per cycle.
- Stall: when out_ready = 0 and both stages are full, in_ready = 0. product and ovf hold stable while out_valid && !out_ready.
- Simultaneous accept and drain in the same cycle is legal; both stages advance together.
- Bubbles: with in_valid = 0, s1_valid clears on the next advance. Data registers may keep stale values; only the valid bits are authoritative.
- Reset (rst_n = 0 sampled at an edge):
  - s1_valid = 0, s2_valid = 0, product = 0, ovf = 0, pa = 0, pb = 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight data. No output is produced for it.
- Ordering is strictly FIFO; no reordering or dropping.

Decomposition:
- Shared package ha_array_pkg:
  - HA_T_W = 9, HA_B_W = 7, HA_ARRAYS = 4, SUM_W = 17.
  - Function row_weight_shift(k) = 2k.
  - typedef ha_row_t as a struct {t, b}.
- One natural sub-module: ha_row_align. It maps (t, b, k) to an aligned 16-bit row. It is instantiated 4 times inside S1.
- Pipeline control lives in the top level.

Test Plan:
- Reset, then ha_array_0_t = 9'h001, all others 0, one valid beat -> after 2 cycles product = 1, ovf = 0; before that beat, in_ready = 1 from the cycle after reset.
- ha_array_3_b = 7'h40 only -> product = 16384 (1<<14), ovf = 0.
- All t inputs = 9'h1FF, all b inputs = 7'h7F -> SAT_EN = 1: product = 16'hFFFF, ovf = 1; SAT_EN = 0: product = 86615 mod 65536 = 21079, ovf = 1.
- Stream 3 beats with values 5, 9, 300 while out_ready = 0 for 4 cycles -> in_ready drops after 2 accepted beats; product holds 5 with out_valid = 1; after release, outputs appear 5, 9, 300 in order with no loss or duplicate.
- Continuous in_valid and out_ready for 100 random beats -> one result per cycle after 2-cycle latency; each result matches the reference sum of weighted bits (sum17, saturated per SAT_EN).
- Assert rst_n = 0 for 1 cycle with both stages full -> next cycle out_valid = 0, product = 0, ovf = 0; the pre-reset beats never appear.
